// File: rtl/hazard_pkg.sv
// Shared constants and types for the decode-stage hazard/forwarding scoreboard.
package hazard_pkg;

    localparam int HZ_REG_W = 5;

    localparam logic [2:0] FWD_RF  = 3'b000;
    localparam logic [2:0] FWD_EX  = 3'b001;
    localparam logic [2:0] FWD_MEM = 3'b010;
    localparam logic [2:0] FWD_WB  = 3'b011;
    localparam logic [2:0] FWD_LU  = 3'b100;

    typedef enum logic [1:0] {
        STG_EX   = 2'd0,
        STG_MEM  = 2'd1,
        STG_WB   = 2'd2,
        STG_NONE = 2'd3
    } stage_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/pipeline side bundle of the hazard scoreboard. StallCount exists only
// when HAZARD_STALL_COUNT_EN is defined.
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int REG_W   = HZ_REG_W
);
    logic [NUM_SRC*REG_W-1:0] ID_Src;
    logic [NUM_SRC-1:0]       ID_SrcUse;
    logic [NUM_SRC-1:0]       ID_SrcNeed;
    logic [REG_W-1:0]         ID_Dest;
    logic                     ID_RegWrite;
    logic                     ID_LongOp;
    logic                     ID_Issue;
    logic [REG_W-1:0]         EX_RtRd;
    logic [REG_W-1:0]         MEM_RtRd;
    logic [REG_W-1:0]         WB_RtRd;
    logic                     EX_RegWrite;
    logic                     MEM_RegWrite;
    logic                     WB_RegWrite;
    logic                     EX_Ready;
    logic                     MEM_Ready;
    logic                     WB_Ready;
    logic                     LU_Done;
    logic [REG_W-1:0]         LU_Dest;
    logic                     Flush;
    logic                     ID_Stall;
    logic [NUM_SRC*3-1:0]     ID_FwdSel;
    logic                     SB_Busy;
`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0]              StallCount;

    modport master (
        output ID_Src, ID_SrcUse, ID_SrcNeed, ID_Dest, ID_RegWrite, ID_LongOp, ID_Issue,
        output EX_RtRd, MEM_RtRd, WB_RtRd, EX_RegWrite, MEM_RegWrite, WB_RegWrite,
        output EX_Ready, MEM_Ready, WB_Ready, LU_Done, LU_Dest, Flush,
        input  ID_Stall, ID_FwdSel, SB_Busy, StallCount
    );

    modport slave (
        input  ID_Src, ID_SrcUse, ID_SrcNeed, ID_Dest, ID_RegWrite, ID_LongOp, ID_Issue,
        input  EX_RtRd, MEM_RtRd, WB_RtRd, EX_RegWrite, MEM_RegWrite, WB_RegWrite,
        input  EX_Ready, MEM_Ready, WB_Ready, LU_Done, LU_Dest, Flush,
        output ID_Stall, ID_FwdSel, SB_Busy, StallCount
    );
`else
    modport master (
        output ID_Src, ID_SrcUse, ID_SrcNeed, ID_Dest, ID_RegWrite, ID_LongOp, ID_Issue,
        output EX_RtRd, MEM_RtRd, WB_RtRd, EX_RegWrite, MEM_RegWrite, WB_RegWrite,
        output EX_Ready, MEM_Ready, WB_Ready, LU_Done, LU_Dest, Flush,
        input  ID_Stall, ID_FwdSel, SB_Busy
    );

    modport slave (
        input  ID_Src, ID_SrcUse, ID_SrcNeed, ID_Dest, ID_RegWrite, ID_LongOp, ID_Issue,
        input  EX_RtRd, MEM_RtRd, WB_RtRd, EX_RegWrite, MEM_RegWrite, WB_RegWrite,
        input  EX_Ready, MEM_Ready, WB_Ready, LU_Done, LU_Dest, Flush,
        output ID_Stall, ID_FwdSel, SB_Busy
    );
`endif

endinterface

// File: rtl/sb_pending_bank.sv
// Pending-write bits for long-latency results, with per-operand lookup that is
// bypassed by a same-cycle completion, plus a registered busy flag.
module sb_pending_bank
    import hazard_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int NUM_REGS = 32,
    parameter int REG_W    = HZ_REG_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     set_i,
    input  logic [REG_W-1:0]         set_idx_i,
    input  logic                     clr_i,
    input  logic [REG_W-1:0]         clr_idx_i,
    input  logic                     flush_i,
    input  logic [NUM_SRC*REG_W-1:0] lookup_idx_i,
    input  logic [REG_W-1:0]         waw_idx_i,
    output logic [NUM_SRC-1:0]       pend_o,
    output logic                     waw_pend_o,
    output logic                     busy_o
);

    logic [NUM_REGS-1:1] pend_q, pend_d;
    logic [NUM_REGS-1:0] pend_full;

    // Register 0 has no storage; it always reads as not pending.
    assign pend_full = {pend_q, 1'b0};

    always_comb begin
        pend_d = pend_q;
        if (flush_i) begin
            pend_d = '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (clr_i && (clr_idx_i == REG_W'(r))) pend_d[r] = 1'b0;
                if (set_i && (set_idx_i == REG_W'(r))) pend_d[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_lookup
        logic [REG_W-1:0] idx;
        assign idx       = lookup_idx_i[i*REG_W +: REG_W];
        assign pend_o[i] = pend_full[idx] && !(clr_i && (clr_idx_i == idx));
    end

    assign waw_pend_o = pend_full[waw_idx_i] && !(clr_i && (clr_idx_i == waw_idx_i));
    assign busy_o     = |pend_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW/WAW hazard detection, forwarding select and long-op scoreboard.
// Optional stall counter enabled by defining HAZARD_STALL_COUNT_EN.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int NUM_REGS = 32,
    parameter int REG_W    = HZ_REG_W
) (
    input  logic              clock,
    input  logic              reset,
    hazard_scoreboard_if.slave hz
);

    logic [NUM_SRC-1:0]   op_pend;
    logic [NUM_SRC-1:0]   stall_op;
    logic [NUM_SRC*3-1:0] fwd_sel;
    logic                 waw_pend;
    logic                 sb_set;
    logic                 id_stall;

    assign sb_set = hz.ID_Issue && hz.ID_LongOp && hz.ID_RegWrite &&
                    (hz.ID_Dest != '0) && !hz.Flush;

    sb_pending_bank #(
        .NUM_SRC  (NUM_SRC),
        .NUM_REGS (NUM_REGS),
        .REG_W    (REG_W)
    ) u_bank (
        .clock        (clock),
        .reset        (reset),
        .set_i        (sb_set),
        .set_idx_i    (hz.ID_Dest),
        .clr_i        (hz.LU_Done),
        .clr_idx_i    (hz.LU_Dest),
        .flush_i      (hz.Flush),
        .lookup_idx_i (hz.ID_Src),
        .waw_idx_i    (hz.ID_Dest),
        .pend_o       (op_pend),
        .waw_pend_o   (waw_pend),
        .busy_o       (hz.SB_Busy)
    );

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_op
        logic [REG_W-1:0] src;
        logic             hit_ex, hit_mem, hit_wb, lu_hit;
        stage_e           win;
        logic             win_rdy;
        logic [2:0]       sel;

        assign src    = hz.ID_Src[i*REG_W +: REG_W];
        assign hit_ex  = hz.ID_SrcUse[i] && hz.EX_RegWrite  && (hz.EX_RtRd  == src) && (src != '0);
        assign hit_mem = hz.ID_SrcUse[i] && hz.MEM_RegWrite && (hz.MEM_RtRd == src) && (src != '0);
        assign hit_wb  = hz.ID_SrcUse[i] && hz.WB_RegWrite  && (hz.WB_RtRd  == src) && (src != '0);
        assign lu_hit  = hz.LU_Done && (hz.LU_Dest == src) && (src != '0);

        // Youngest in-flight producer wins; an unready winner blocks older copies.
        always_comb begin
            win     = STG_NONE;
            win_rdy = 1'b1;
            if (hit_ex) begin
                win     = STG_EX;
                win_rdy = hz.EX_Ready;
            end else if (hit_mem) begin
                win     = STG_MEM;
                win_rdy = hz.MEM_Ready;
            end else if (hit_wb) begin
                win     = STG_WB;
                win_rdy = hz.WB_Ready;
            end

            sel = FWD_RF;
            case (win)
                STG_EX:   sel = win_rdy ? FWD_EX  : FWD_RF;
                STG_MEM:  sel = win_rdy ? FWD_MEM : FWD_RF;
                STG_WB:   sel = win_rdy ? FWD_WB  : FWD_RF;
                default:  sel = lu_hit  ? FWD_LU  : FWD_RF;
            endcase
        end

        assign fwd_sel[i*3 +: 3] = sel;
        assign stall_op[i] = hz.ID_SrcNeed[i] &&
                             (((win != STG_NONE) && !win_rdy) || op_pend[i]);
    end

    assign id_stall     = (|stall_op) || (hz.ID_RegWrite && (hz.ID_Dest != '0) && waw_pend);
    assign hz.ID_Stall  = id_stall;
    assign hz.ID_FwdSel = fwd_sel;

`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (id_stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign hz.StallCount = stall_cnt_q;
`endif

endmodule
